mdu_e: RTL and testbench

MDU_E -- requirements
Module: mdu_e

---
 rtl/mdu_e.sv | 164 ++++++++++++++++
 tb/tb_mdu_e.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: owns HI/LO and holds busy for a fixed latency
// per operation so the pipeline stall controller can treat it as a black box.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e          r_state;
  state_e          w_stateNext;
  op_e             r_op;
  op_e             w_opIn;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_acceptLong;
  logic            w_done;
  logic            w_writeEn;
  logic [31:0]     w_resHi;
  logic [31:0]     w_resLo;

  logic [63:0]     w_prodS;
  logic [63:0]     w_prodU;
  logic [31:0]     w_divisor;
  logic [31:0]     w_magA;
  logic [31:0]     w_magB;
  logic [31:0]     w_qMag;
  logic [31:0]     w_rMag;
  logic [31:0]     w_quoS;
  logic [31:0]     w_remS;
  logic [31:0]     w_quoU;
  logic [31:0]     w_remU;

  assign w_opIn       = op_e'(mdu_op);
  assign w_accept     = start && (r_state == S_IDLE) && (w_opIn inside {[OP_MULT:OP_MTLO]});
  assign w_acceptLong = w_accept && (w_opIn inside {[OP_MULT:OP_DIVU]});
  assign w_done       = (r_state == S_BUSY) && (r_count == '0);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (w_acceptLong) w_stateNext = S_BUSY;
      S_BUSY: if (w_done)       w_stateNext = S_IDLE;
      default:                  w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  // Products are formed from the latched operands so input churn while busy is harmless.
  assign w_prodS = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prodU = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide works on magnitudes; 0x80000000 / -1 then wraps to 0x80000000 naturally.
  assign w_divisor = (r_b == 32'd0) ? 32'd1 : r_b;
  assign w_magA    = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_magB    = w_divisor[31] ? (32'd0 - w_divisor) : w_divisor;
  assign w_qMag    = w_magA / w_magB;
  assign w_rMag    = w_magA % w_magB;
  assign w_quoS    = (r_a[31] ^ r_b[31]) ? (32'd0 - w_qMag) : w_qMag;
  assign w_remS    = r_a[31] ? (32'd0 - w_rMag) : w_rMag;
  assign w_quoU    = r_a / w_divisor;
  assign w_remU    = r_a % w_divisor;

  always_comb begin
    w_resHi   = r_hi;
    w_resLo   = r_lo;
    w_writeEn = 1'b1;
    case (r_op)
      OP_MULT: begin
        w_resHi = w_prodS[63:32];
        w_resLo = w_prodS[31:0];
      end
      OP_MULTU: begin
        w_resHi = w_prodU[63:32];
        w_resLo = w_prodU[31:0];
      end
      OP_DIV: begin
        w_resHi   = w_remS;
        w_resLo   = w_quoS;
        w_writeEn = (r_b != 32'd0);
      end
      OP_DIVU: begin
        w_resHi   = w_remU;
        w_resLo   = w_quoU;
        w_writeEn = (r_b != 32'd0);
      end
      default: w_writeEn = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= OP_NONE;
      r_count <= '0;
    end else if (w_accept) begin
      case (w_opIn)
        OP_MTHI: r_hi <= a;
        OP_MTLO: r_lo <= a;
        default: begin
          r_a     <= a;
          r_b     <= b;
          r_op    <= w_opIn;
          r_count <= (w_opIn inside {OP_DIV, OP_DIVU}) ? DIV_LOAD : MULT_LOAD;
        end
      endcase
    end else if (r_state == S_BUSY) begin
      if (w_done) begin
        if (w_writeEn) begin
          r_hi <= w_resHi;
          r_lo <= w_resLo;
        end
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign busy = (r_state == S_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_e.sv
// Self-checking bench for mdu_e: directed vector table, hand-written corner
// sequences and random operations scored against an arithmetic HI/LO model.
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expCycles;
  } vec_t;

  vec_t vecs[10];

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int opCycles(input logic [2:0] op);
    case (op)
      3'd1, 3'd2: return 5;
      3'd3, 3'd4: return 10;
      default:    return 0;
    endcase
  endfunction

  // Architectural effect of one accepted operation on HI/LO.
  task automatic modelStep(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint      x, y, q, r;
    logic [63:0] p;
    case (op)
      3'd1: begin
        p = 64'(longint'($signed(av)) * longint'($signed(bv)));
        mHi = p[63:32];
        mLo = p[31:0];
      end
      3'd2: begin
        p = {32'd0, av} * {32'd0, bv};
        mHi = p[63:32];
        mLo = p[31:0];
      end
      3'd3: if (bv != 32'd0) begin
        x = longint'($signed(av));
        y = longint'($signed(bv));
        q = x / y;
        r = x % y;
        mLo = q[31:0];
        mHi = r[31:0];
      end
      3'd4: if (bv != 32'd0) begin
        mLo = av / bv;
        mHi = av % bv;
      end
      3'd5: mHi = av;
      3'd6: mLo = av;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the first negedge where busy is low.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                               output int cycles, output logic earlyChange);
    logic [31:0] preHi, preLo;
    preHi  = hi;
    preLo  = lo;
    start  = 1'b1;
    mdu_op = op;
    a      = av;
    b      = bv;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'($urandom_range(0, 7));
    a      = $urandom;
    b      = $urandom;
    cycles = 0;
    earlyChange = 1'b0;
    while (busy && cycles < 40) begin
      cycles++;
      if (hi !== preHi || lo !== preLo) earlyChange = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    int          cyc;
    logic        early;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd5, 32'h12345678, 32'd9,        32'h12345678, 32'h80000000, 0};
    vecs[6] = '{3'd6, 32'hCAFEBABE, 32'd9,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[7] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[9] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

    // Reset, held together with a start to show reset wins.
    reset  = 1'b1;
    start  = 1'b1;
    mdu_op = 3'd5;
    a      = 32'h77;
    b      = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, cyc, early);
      modelStep(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].expCycles));
      checkOutput($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
      checkOutput($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
      checkOutput($sformatf("vec%0d_early_update", i), {31'd0, early}, 32'd0);
    end

    $display("[TB] start while busy");
    start  = 1'b1;
    mdu_op = 3'd1;
    a      = 32'h00010003;
    b      = 32'hFFFF0005;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 1) begin
        start = 1'b1; mdu_op = 3'd3; a = 32'd100; b = 32'd7;
      end else if (cyc == 2) begin
        start = 1'b1; mdu_op = 3'd6; a = 32'h1234;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    modelStep(3'd1, 32'h00010003, 32'hFFFF0005);
    checkOutput("busy_ignore_cycles", 32'(cyc), 32'd5);
    checkOutput("busy_ignore_hi", hi, mHi);
    checkOutput("busy_ignore_lo", lo, mLo);
    @(negedge clk);
    checkOutput("busy_ignore_idle_after", {31'd0, busy}, 32'd0);
    checkOutput("busy_ignore_lo_after", lo, mLo);

    $display("[TB] reset mid-operation");
    applyStimulus(3'd5, 32'h55, 32'd0, cyc, early);
    applyStimulus(3'd6, 32'h55, 32'd0, cyc, early);
    checkOutput("pre_reset_hi", hi, 32'h55);
    checkOutput("pre_reset_lo", lo, 32'h55);
    start  = 1'b1;
    mdu_op = 3'd3;
    a      = 32'd100;
    b      = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mid_reset_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mHi = 32'd0;
    mLo = 32'd0;
    checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_reset_hi", hi, 32'd0);
    checkOutput("mid_reset_lo", lo, 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post_reset%0d_busy", i), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("post_reset%0d_hi", i), hi, 32'd0);
      checkOutput($sformatf("post_reset%0d_lo", i), lo, 32'd0);
    end

    $display("[TB] divide by zero then back-to-back mthi");
    applyStimulus(3'd5, 32'hAAAA0000, 32'd0, cyc, early);
    applyStimulus(3'd6, 32'h0000BBBB, 32'd0, cyc, early);
    applyStimulus(3'd4, 32'h13572468, 32'd0, cyc, early);
    checkOutput("divz_cycles", 32'(cyc), 32'd10);
    checkOutput("divz_hi", hi, 32'hAAAA0000);
    checkOutput("divz_lo", lo, 32'h0000BBBB);
    applyStimulus(3'd5, 32'h1, 32'd0, cyc, early);
    checkOutput("divz_mthi_cycles", 32'(cyc), 32'd0);
    checkOutput("divz_mthi_hi", hi, 32'h1);
    checkOutput("divz_mthi_lo", lo, 32'h0000BBBB);
    mHi = 32'h1;
    mLo = 32'h0000BBBB;

    $display("[TB] random operations");
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 11) == 0) begin
        ra = 32'h80000000;
        rb = 32'hFFFFFFFF;
      end
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000001F;
      applyStimulus(rop, ra, rb, cyc, early);
      modelStep(rop, ra, rb);
      checkOutput($sformatf("rand%0d_op%0d_cycles", i, rop), 32'(cyc), 32'(opCycles(rop)));
      checkOutput($sformatf("rand%0d_op%0d_hi", i, rop), hi, mHi);
      checkOutput($sformatf("rand%0d_op%0d_lo", i, rop), lo, mLo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
